// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - execution sequencer for the 5-stage MIPS pipeline
//
// Purpose:
//   Drives the pipeline register enables for continuous or single-step
//   execution, folds in the hazard unit's stall / HALT indications, drains
//   in-flight instructions after HALT and reports completion. Keeps an
//   executed-cycle counter (and optionally a stall counter) for the debug unit.
//
// Optional feature:
//   PIPELINE_SEQUENCER_STALL_CNT_EN - when defined, o_stall_count counts
//   stall-path cycles; when undefined, o_stall_count is tied to 0.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_start          start pulse (IDLE only), i_mode sampled with it
//   i_mode           0 = continuous, 1 = single-step
//   i_step           single-step pulse (STEP_WAIT only)
//   i_flush          abort: pipeline clear, back to IDLE from any state
//   i_halt_detected  HALT opcode in IF/ID
//   i_hazard_stall   load/data hazard stall request
//   o_pc_enable      PC write enable
//   o_if_id_enable   IF/ID write enable
//   o_id_ex_bubble   load NOP into ID/EX
//   o_pipe_enable    enable for ID/EX, EX/MEM, MEM/WB and RF/memory writes
//   o_pipe_flush     one-cycle clear of all pipeline registers
//   o_busy           RUN, STEP_WAIT, STEP_EXEC or DRAIN
//   o_done           DONE
//   o_cycle_count    executed clock cycles (saturating)
//   o_stall_count    hazard bubble cycles (saturating, optional)

module pipeline_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic                 i_step,
  input  logic                 i_flush,
  input  logic                 i_halt_detected,
  input  logic                 i_hazard_stall,
  output logic                 o_pc_enable,
  output logic                 o_if_id_enable,
  output logic                 o_id_ex_bubble,
  output logic                 o_pipe_enable,
  output logic                 o_pipe_flush,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cycle_count,
  output logic [CNT_WIDTH-1:0] o_stall_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [3:0]           DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [3:0]           drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;

  logic exec_cycle;   // RUN or STEP_EXEC: a normal instruction-advancing cycle
  logic start_take;
  logic count_cycle;

  always_comb begin
    exec_cycle  = (state_q == S_RUN) || (state_q == S_STEP_EXEC);
    start_take  = (state_q == S_IDLE) && i_start && !i_flush;
    count_cycle = !i_flush && (exec_cycle || (state_q == S_DRAIN));
  end

  // Next-state and drain counter. Flush overrides everything, including
  // a simultaneous start or step.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (i_flush) begin
      state_d     = S_IDLE;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = i_mode ? S_STEP_WAIT : S_RUN;
          end
        end
        S_RUN: begin
          if (i_halt_detected) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
        S_STEP_WAIT: begin
          if (i_step) begin
            state_d = S_STEP_EXEC;
          end
        end
        S_STEP_EXEC: begin
          if (i_halt_detected) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else begin
            state_d = S_STEP_WAIT;
          end
        end
        S_DRAIN: begin
          // Leaving when the counter reads 1 yields exactly DRAIN_CYCLES
          // DRAIN cycles; the <= guard also covers a stray zero.
          drain_cnt_d = (drain_cnt_q == 4'd0) ? 4'd0 : (drain_cnt_q - 4'd1);
          if (drain_cnt_q <= 4'd1) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d     = S_IDLE;
          drain_cnt_d = '0;
        end
      endcase
    end
  end

  // Executed-cycle counter: cleared on start or flush, saturates at all-ones.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (i_flush || start_take) begin
      cycle_cnt_d = '0;
    end else if (count_cycle && (cycle_cnt_q != CNT_MAX)) begin
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

`ifdef PIPELINE_SEQUENCER_STALL_CNT_EN
  logic                 stall_take;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Halt has priority over stall, so a halt+stall cycle is not a stall.
  always_comb begin
    stall_take  = exec_cycle && !i_flush && !i_halt_detected && i_hazard_stall;
    stall_cnt_d = stall_cnt_q;
    if (i_flush || start_take) begin
      stall_cnt_d = '0;
    end else if (stall_take && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
`else
  assign o_stall_count = '0;
`endif

  // Stage enables are combinational so a hazard or HALT seen in IF/ID
  // freezes PC and IF/ID in the very same cycle. The reset term keeps a
  // flush request from reaching the pipeline while reset is held.
  always_comb begin
    o_pc_enable    = 1'b0;
    o_if_id_enable = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_enable  = 1'b0;
    o_pipe_flush   = 1'b0;
    if (!i_reset_n) begin
      o_pipe_flush = 1'b0;
    end else if (i_flush) begin
      o_pipe_flush = 1'b1;
    end else begin
      case (state_q)
        S_RUN, S_STEP_EXEC: begin
          o_pipe_enable = 1'b1;
          if (i_halt_detected || i_hazard_stall) begin
            o_id_ex_bubble = 1'b1;
          end else begin
            o_pc_enable    = 1'b1;
            o_if_id_enable = 1'b1;
          end
        end
        S_DRAIN: begin
          o_pipe_enable  = 1'b1;
          o_id_ex_bubble = 1'b1;
        end
        default: begin
          o_pipe_enable = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_busy = (state_q == S_RUN) || (state_q == S_STEP_WAIT) ||
             (state_q == S_STEP_EXEC) || (state_q == S_DRAIN);
    o_done = (state_q == S_DONE);
  end

  assign o_cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - self-checking bench for pipeline_sequencer

module tb_pipeline_sequencer;

  localparam int DC = 4;
  localparam int CW = 8;
`ifdef PIPELINE_SEQUENCER_STALL_CNT_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif

  // Inputs: {start, mode, step, flush, halt, stall}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_START = 6'b100000;
  localparam logic [5:0] I_SSTEP = 6'b110000;
  localparam logic [5:0] I_STEP  = 6'b001000;
  localparam logic [5:0] I_FLUSH = 6'b000100;
  localparam logic [5:0] I_HALT  = 6'b000010;
  localparam logic [5:0] I_STALL = 6'b000001;

  // Outputs: {pc, if_id, bubble, pipe_en, pipe_flush, busy, done}
  localparam logic [6:0] O_IDLE    = 7'b0000000;
  localparam logic [6:0] O_RUN     = 7'b1101010;
  localparam logic [6:0] O_BUB     = 7'b0011010;
  localparam logic [6:0] O_WAIT    = 7'b0000010;
  localparam logic [6:0] O_DONE    = 7'b0000001;
  localparam logic [6:0] O_FL_IDLE = 7'b0000100;
  localparam logic [6:0] O_FL_BUSY = 7'b0000110;
  localparam logic [6:0] O_FL_DONE = 7'b0000101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, mode = 1'b0, stp = 1'b0, flush = 1'b0, halt = 1'b0, stall = 1'b0;
  logic pc, ifid, bub, pen, pfl, busy, done;
  logic [CW-1:0] cyc, stl;

  always #5 clk = ~clk;

  pipeline_sequencer #(.DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_mode(mode),
    .i_step(stp), .i_flush(flush), .i_halt_detected(halt), .i_hazard_stall(stall),
    .o_pc_enable(pc), .o_if_id_enable(ifid), .o_id_ex_bubble(bub),
    .o_pipe_enable(pen), .o_pipe_flush(pfl), .o_busy(busy), .o_done(done),
    .o_cycle_count(cyc), .o_stall_count(stl)
  );

  typedef struct {
    string      name;
    logic [5:0] ins;
    logic [6:0] outs;
    int         cyc;
    int         stl;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic add(string nm, logic [5:0] ins, logic [6:0] outs, int c, int s);
    vec_t v;
    v.name = nm; v.ins = ins; v.outs = outs; v.cyc = c; v.stl = s;
    tbl.push_back(v);
  endtask

  task automatic check(string nm, logic [6:0] eo, int ec, int es);
    logic [6:0] ao;
    int ac, a_s;
    ao  = {pc, ifid, bub, pen, pfl, busy, done};
    ac  = int'(cyc);
    a_s = int'(stl);
    n_total++;
    if (ao === eo && ac == ec && a_s == es) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got out=%b cyc=%0d stl=%0d, expected out=%b cyc=%0d stl=%0d",
               nm, ao, ac, a_s, eo, ec, es);
    end
  endtask

  task automatic set_in(logic [5:0] v);
    {start, mode, stp, flush, halt, stall} = v;
  endtask

  // Scoreboard: each driven vector's expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      check(e.name, e.outs, e.cyc, e.stl);
    end
  end

  initial begin
    // Idle corner cases: flush in IDLE, flush beats start, step ignored
    add("reset_idle",       I_NONE,            O_IDLE,    0, 0);
    add("idle_flush",       I_FLUSH,           O_FL_IDLE, 0, 0);
    add("idle_flush_start", I_FLUSH | I_START, O_FL_IDLE, 0, 0);
    add("idle_step_ign",    I_STEP,            O_IDLE,    0, 0);
    add("idle_hold",        I_NONE,            O_IDLE,    0, 0);

    // Continuous run, halt, drain, done hold
    add("run_start", I_START, O_IDLE, 0, 0);
    for (int k = 1; k <= 10; k++) add("run", I_NONE, O_RUN, k - 1, 0);
    add("run_halt", I_HALT, O_BUB, 10, 0);
    for (int k = 0; k < DC; k++) add("drain", I_NONE, O_BUB, 11 + k, 0);
    add("done",         I_NONE,  O_DONE,    15, 0);
    add("done_start",   I_START, O_DONE,    15, 0);
    add("done_hold",    I_NONE,  O_DONE,    15, 0);
    add("done_flush",   I_FLUSH, O_FL_DONE, 15, 0);
    add("idle_cleared", I_NONE,  O_IDLE,    0, 0);

    // Stall, then halt+stall priority, then flush+step mid-drain
    add("st_start",        I_START,          O_IDLE,    0, 0);
    add("st_run",          I_NONE,           O_RUN,     0, 0);
    add("st_stall1",       I_STALL,          O_BUB,     1, 0);
    add("st_stall2",       I_STALL,          O_BUB,     2, SC);
    add("st_resume",       I_NONE,           O_RUN,     3, 2 * SC);
    add("pr_halt_stall",   I_HALT | I_STALL, O_BUB,     4, 2 * SC);
    add("pr_drain1",       I_STALL,          O_BUB,     5, 2 * SC);
    add("pr_drain2_flush", I_FLUSH | I_STEP, O_FL_BUSY, 6, 2 * SC);
    add("pr_idle",         I_NONE,           O_IDLE,    0, 0);

    // Single-step: three pulses five cycles apart
    add("sp_start", I_SSTEP, O_IDLE, 0, 0);
    for (int p = 0; p < 3; p++) begin
      for (int w = 0; w < 3; w++) add("sp_wait", I_NONE, O_WAIT, p, 0);
      add("sp_step", I_STEP, O_WAIT, p, 0);
      add("sp_exec", I_NONE, O_RUN, p, 0);
    end
    add("sp_wait_end",   I_NONE,  O_WAIT, 3, 0);
    add("sp_step4",      I_STEP,  O_WAIT, 3, 0);
    add("sp_exec_stall", I_STALL, O_BUB,  3, 0);
    add("sp_step5",      I_STEP,  O_WAIT, 4, SC);
    add("sp_exec_halt",  I_HALT,  O_BUB,  4, SC);
    for (int k = 0; k < DC; k++) add("sp_drain", (k == 1) ? I_STEP : I_NONE, O_BUB, 5 + k, SC);
    add("sp_done",       I_NONE,  O_DONE,    9, SC);
    add("sp_done_flush", I_FLUSH, O_FL_DONE, 9, SC);
    add("sp_idle",       I_NONE,  O_IDLE,    0, 0);

    // Cycle counter saturation at 2^CW-1
    add("sat_start", I_START, O_IDLE, 0, 0);
    for (int k = 0; k < 260; k++) add("sat_run", I_NONE, O_RUN, (k > 255) ? 255 : k, 0);
    add("sat_flush", I_FLUSH, O_FL_BUSY, 255, 0);
    add("sat_idle",  I_NONE,  O_IDLE,    0, 0);

    // Outputs while reset is held
    @(negedge clk);
    check("rst_held", O_IDLE, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      set_in(tbl[i].ins);
      sb.push_back(tbl[i]);
    end
    @(posedge clk); #1;
    set_in(I_NONE);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN, no clock edge involved
    @(posedge clk); #1;
    set_in(I_START);
    @(posedge clk); #1;
    set_in(I_NONE);
    @(posedge clk); #2;
    check("arst_pre", O_RUN, 1, 0);
    rst_n = 1'b0;
    #1;
    check("arst_async", O_IDLE, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release", O_IDLE, 0, 0);
    @(posedge clk); #1;
    set_in(I_START);
    @(posedge clk); #1;
    set_in(I_NONE);
    @(negedge clk);
    check("arst_restart", O_RUN, 0, 0);
    @(posedge clk); #1;
    set_in(I_FLUSH);
    @(posedge clk); #1;
    set_in(I_NONE);
    @(negedge clk);
    check("arst_end_idle", O_IDLE, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
